// File: rtl/lsu_bus_adapter.sv
// Load/store unit to single-outstanding bus adapter: IDLE -> BUS -> DONE handshake with lane steering,
// load extension and bus-wait timeout. Define LSU_MISALIGN_TRAP_EN to fault misaligned H/W accesses.
module lsu_bus_adapter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       funct3_q;
  logic [1:0]       offset_q;
  logic             trap;

  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  // funct3[2] selects zero extension; codes 011/110/111 fall through to a word.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{off, 3'b000} +: 8];
    h = off[1] ? d[31:16] : d[15:0];
    case (f3[1:0])
      2'b00:   return f3[2] ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   return f3[2] ? {16'd0, h} : {{16{h[15]}}, h};
      default: return d;
    endcase
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

  assign trap = misaligned(req_funct3, req_addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  // Stall must rise in the accept cycle itself so the PC does not advance past the access.
  assign stall = (state == BUS) || ((state == IDLE) && req_valid);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      funct3_q  <= 3'd0;
      offset_q  <= 2'd0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_wdata <= 32'd0;
      bus_be    <= 4'd0;
      rdata     <= 32'd0;
      done      <= 1'b0;
      fault     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            funct3_q <= req_funct3;
            offset_q <= req_addr[1:0];
            if (trap) begin
              state <= DONE;
              done  <= 1'b1;
              fault <= 1'b1;
              rdata <= 32'd0;
            end else begin
              state     <= BUS;
              cnt       <= '0;
              bus_req   <= 1'b1;
              bus_we    <= req_we;
              bus_addr  <= {req_addr[31:2], 2'b00};
              bus_wdata <= lane_wdata(req_funct3, req_wdata);
              bus_be    <= lane_be(req_funct3, req_addr[1:0]);
            end
          end
        end
        // Ack takes priority over a timeout expiring in the same cycle.
        BUS: begin
          if (bus_ack) begin
            state   <= DONE;
            bus_req <= 1'b0;
            done    <= 1'b1;
            fault   <= 1'b0;
            if (!bus_we) rdata <= load_extend(funct3_q, offset_q, bus_rdata);
          end else if ((TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST)) begin
            state   <= DONE;
            bus_req <= 1'b0;
            done    <= 1'b1;
            fault   <= 1'b1;
            rdata   <= 32'd0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          fault <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus_adapter.sv
// Self-checking bench for lsu_bus_adapter: table-driven transactions with a result scoreboard,
// plus hand-written timeout and reset-abort sequences on a second instance with TIMEOUT_CYCLES=4.
module tb_lsu_bus_adapter;

  logic        clk;
  logic        reset;
  logic        req_valid, req_valid_t;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  logic        stall, done, fault, bus_req, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_be;

  logic        stall_t, done_t, fault_t, bus_req_t, bus_we_t;
  logic [31:0] rdata_t, bus_addr_t, bus_wdata_t;
  logic [3:0]  bus_be_t;

  lsu_bus_adapter #(.TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall), .done(done), .rdata(rdata),
    .fault(fault), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_be(bus_be), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  lsu_bus_adapter #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .reset(reset), .req_valid(req_valid_t), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall_t), .done(done_t), .rdata(rdata_t),
    .fault(fault_t), .bus_req(bus_req_t), .bus_we(bus_we_t), .bus_addr(bus_addr_t),
    .bus_wdata(bus_wdata_t), .bus_be(bus_be_t), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] brd;
    int          ack_at;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic [31:0] e_rd;
    bit          trap;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        fault;
  } exp_t;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam int NVEC = 15;
  vec_t        vecs[NVEC];
  exp_t        exp_q[$];
  logic [31:0] model_rd;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic do_txn(input vec_t v);
    int   cyc;
    int   bus_cyc;
    bit   got;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr;
    req_wdata = v.wdata; bus_rdata = v.brd; bus_ack = 1'b0;
    if (v.trap) begin
      e.rd = 32'd0; e.fault = 1'b1; model_rd = 32'd0;
    end else if (v.we) begin
      e.rd = model_rd; e.fault = 1'b0;
    end else begin
      e.rd = v.e_rd; e.fault = 1'b0; model_rd = v.e_rd;
    end
    exp_q.push_back(e);
    #1 check("stall_on_accept", stall, 1);
    cyc = 0; bus_cyc = 0; got = 0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done) got = 1;
      else begin
        bus_cyc++;
        check("bus_req_held", bus_req, 1);
        check("stall_in_bus", stall, 1);
        check("bus_addr", bus_addr, v.e_addr);
        check("bus_we", bus_we, v.we);
        if (v.we) begin
          check("bus_be", bus_be, v.e_be);
          check("bus_wdata", bus_wdata, v.e_wd);
        end
        bus_ack = (bus_cyc == v.ack_at);
      end
    end
    if (!got) begin
      errors++; checks++;
      $display("FAIL done_wait: no done after %0d cycles", cyc);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else if (exp_q.size() == 0) begin
      errors++; checks++;
      $display("FAIL scoreboard: done with empty queue");
    end else begin
      e = exp_q.pop_front();
      check("rdata", rdata, e.rd);
      check("fault", fault, e.fault);
      check("stall_in_done", stall, 0);
      check("bus_req_dropped", bus_req, 0);
      check("bus_cycles", bus_cyc, v.trap ? 0 : v.ack_at);
    end
    req_valid = 1'b0; bus_ack = 1'b0;
    @(negedge clk);
    check("done_one_pulse", done, 0);
    check("fault_outside_done", fault, 0);
  endtask

  // ack_at = 0 means never acknowledge
  task automatic to_txn(input int ack_at, input logic [31:0] brd, input logic [31:0] e_rd,
                        input logic e_fault);
    int   cyc;
    int   bus_cyc;
    bit   got;
    exp_t e;
    @(negedge clk);
    req_valid_t = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h300;
    bus_rdata = brd; bus_ack = 1'b0;
    e.rd = e_rd; e.fault = e_fault;
    exp_q.push_back(e);
    cyc = 0; bus_cyc = 0; got = 0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done_t) got = 1;
      else begin
        bus_cyc++;
        check("to_bus_req", bus_req_t, 1);
        bus_ack = (bus_cyc == ack_at);
      end
    end
    if (!got) begin
      errors++; checks++;
      $display("FAIL to_done_wait: no done after %0d cycles", cyc);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      check("to_bus_cycles", bus_cyc, 4);
      check("to_bus_req_dropped", bus_req_t, 0);
      check("to_rdata", rdata_t, e.rd);
      check("to_fault", fault_t, e.fault);
    end
    req_valid_t = 1'b0; bus_ack = 1'b0;
    @(negedge clk);
    check("to_done_one_pulse", done_t, 0);
    check("to_fault_outside_done", fault_t, 0);
  endtask

  initial begin
    //          we    f3      addr       wdata         brd          ack e_addr   e_be     e_wd          e_rd          trap
    vecs[0]  = '{1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0,        1, 32'h100, 4'b1000, 32'hA5A5A5A5, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 3'b000, 32'h202, 32'h0,        32'h0080FF00, 1, 32'h200, 4'b0000, 32'h0,        32'hFFFFFF80, 1'b0};
    vecs[2]  = '{1'b0, 3'b100, 32'h202, 32'h0,        32'h0080FF00, 1, 32'h200, 4'b0000, 32'h0,        32'h00000080, 1'b0};
    vecs[3]  = '{1'b0, 3'b001, 32'h102, 32'h0,        32'h80011234, 1, 32'h100, 4'b0000, 32'h0,        32'hFFFF8001, 1'b0};
    vecs[4]  = '{1'b0, 3'b101, 32'h100, 32'h0,        32'h80019234, 1, 32'h100, 4'b0000, 32'h0,        32'h00009234, 1'b0};
    vecs[5]  = '{1'b0, 3'b010, 32'h104, 32'h0,        32'hDEADBEEF, 5, 32'h104, 4'b0000, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[6]  = '{1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0,        1, 32'h100, 4'b1100, 32'hABCDABCD, 32'h0,        1'b0};
    vecs[7]  = '{1'b1, 3'b010, 32'h108, 32'h11223344, 32'h0,        2, 32'h108, 4'b1111, 32'h11223344, 32'h0,        1'b0};
    vecs[8]  = '{1'b0, 3'b011, 32'h10C, 32'h0,        32'hCAFEF00D, 1, 32'h10C, 4'b0000, 32'h0,        32'hCAFEF00D, 1'b0};
    vecs[9]  = '{1'b1, 3'b111, 32'h110, 32'h55667788, 32'h0,        1, 32'h110, 4'b1111, 32'h55667788, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 3'b110, 32'h114, 32'h0,        32'h0BADF00D, 1, 32'h114, 4'b0000, 32'h0,        32'h0BADF00D, 1'b0};
    vecs[11] = '{1'b1, 3'b000, 32'h101, 32'hFFFFFF7E, 32'h0,        1, 32'h100, 4'b0010, 32'h7E7E7E7E, 32'h0,        1'b0};
    vecs[12] = '{1'b0, 3'b000, 32'h203, 32'h0,        32'h7F000000, 1, 32'h200, 4'b0000, 32'h0,        32'h0000007F, 1'b0};
    vecs[13] = '{1'b0, 3'b010, 32'h102, 32'h0,        32'h89ABCDEF, 1, 32'h100, 4'b0000, 32'h0,        32'h89ABCDEF, TRAP};
    vecs[14] = '{1'b1, 3'b001, 32'h101, 32'h0000BEEF, 32'h0,        1, 32'h100, 4'b0011, 32'hBEEFBEEF, 32'h0,        TRAP};

    reset = 1'b1; req_valid = 1'b0; req_valid_t = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; bus_rdata = 32'd0; bus_ack = 1'b0;
    model_rd = 32'd0;
    #2;
    check("rst_bus_req", bus_req, 0);
    check("rst_bus_we", bus_we, 0);
    check("rst_bus_be", bus_be, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_wdata", bus_wdata, 0);
    check("rst_rdata", rdata, 0);
    check("rst_done", done, 0);
    check("rst_fault", fault, 0);
    check("rst_stall_idle", stall, 0);
    req_valid = 1'b1;
    #1 check("rst_stall_follows", stall, 1);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) do_txn(vecs[i]);

    // timeout instance: ack exactly on the 4th bus cycle wins, then no ack at all
    to_txn(4, 32'h12345678, 32'h12345678, 1'b0);
    to_txn(0, 32'hFFFFFFFF, 32'h0, 1'b1);

    // reset while waiting for ack abandons the access; a later ack is ignored
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h400; bus_ack = 1'b0;
    @(negedge clk);
    check("mid_bus_req_before", bus_req, 1);
    #1 reset = 1'b1;
    #1;
    check("mid_bus_req_cleared", bus_req, 0);
    check("mid_bus_addr_cleared", bus_addr, 0);
    check("mid_rdata_cleared", rdata, 0);
    check("mid_stall_follows", stall, 1);
    req_valid = 1'b0;
    #1 check("mid_stall_released", stall, 0);
    @(negedge clk);
    reset = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hAAAA5555;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("late_ack_no_done", done, 0);
      check("late_ack_no_bus_req", bus_req, 0);
      check("late_ack_rdata", rdata, 0);
    end
    bus_ack = 1'b0;
    model_rd = 32'd0;
    do_txn(vecs[2]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
